// File: rtl/uart_sipo_deserializer.sv
// uart_sipo_deserializer: serial-in/parallel-out word assembler for the UART
// receive path. It shifts sampled bits into a frame, commits the data bits to a
// held output with a valid/ready handshake, and flags short frames and overruns.
// Optional feature: define UART_SIPO_PARITY_EN to append a parity bit to each
// frame and report parity_err for the committed word.
module uart_sipo_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  data_in,
  input  logic                  read,
  input  logic                  data_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            bit_cnt,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

`ifdef UART_SIPO_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int         FRAME_LEN   = DATA_WIDTH + PAR_BITS;
  localparam logic [4:0] FRAME_LEN_C = 5'(FRAME_LEN);

  // Insert one bit at the end selected by LSB_FIRST; after FRAME_LEN shifts the
  // first received bit sits at bit 0 (LSB_FIRST=1) or at the top (LSB_FIRST=0).
  function automatic logic [FRAME_LEN-1:0] shift_in(input logic [FRAME_LEN-1:0] sr,
                                                    input logic b);
    logic [FRAME_LEN:0] t;
    if (LSB_FIRST) begin
      t = {b, sr};
      return t[FRAME_LEN:1];
    end else begin
      t = {sr, b};
      return t[FRAME_LEN-1:0];
    end
  endfunction

  // Data bits of a full frame; the parity bit (if any) is the last one received.
  function automatic logic [DATA_WIDTH-1:0] frame_data(input logic [FRAME_LEN-1:0] sr);
    if (LSB_FIRST) return sr[DATA_WIDTH-1:0];
    else           return sr[FRAME_LEN-1 -: DATA_WIDTH];
  endfunction

  // Even parity expects XOR(data, parity) == 0, odd parity expects 1.
  function automatic logic parity_fail(input logic [DATA_WIDTH-1:0] d, input logic p);
    return ((^d) ^ p) != PARITY_ODD;
  endfunction

  logic [FRAME_LEN-1:0]  sr_q, sr_d;
  logic [4:0]            cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ferr_q, ferr_d;
  logic                  overrun_q, overrun_d;
  logic                  perr_q, perr_d;
  logic                  commit_ok;

  // Next-state: commit/handshake on the pre-cycle state, then frame sequencing.
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    full_d      = full_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ferr_d      = 1'b0;
    overrun_d   = overrun_q;
    perr_d      = perr_q;
    commit_ok   = data_valid && full_q && (!out_valid_q || out_ready);

    if (commit_ok) begin
      out_d       = frame_data(sr_q);
      out_valid_d = 1'b1;
`ifdef UART_SIPO_PARITY_EN
      perr_d      = parity_fail(frame_data(sr_q), LSB_FIRST ? sr_q[FRAME_LEN-1] : sr_q[0]);
`endif
    end else begin
      // A full frame with the held word still pending is lost.
      if (data_valid && full_q) overrun_d = 1'b1;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
    end

    if (data_valid && !full_q) ferr_d = 1'b1;

    if (frame_start) begin
      cnt_d  = 5'd0;
      full_d = 1'b0;
    end else if (data_valid) begin
      // A short commit still takes its same-cycle bit; a full one ignores it.
      cnt_d  = 5'd0;
      full_d = 1'b0;
      if (read && !full_q) sr_d = shift_in(sr_q, data_in);
    end else if (read && !full_q) begin
      sr_d   = shift_in(sr_q, data_in);
      cnt_d  = cnt_q + 5'd1;
      full_d = (cnt_q + 5'd1) == FRAME_LEN_C;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q        <= '0;
      cnt_q       <= 5'd0;
      full_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      full_q      <= full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
      perr_q      <= perr_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign bit_cnt   = cnt_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
`ifdef UART_SIPO_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sipo_deserializer.sv
// Bench for uart_sipo_deserializer: two instances (LSB-first and MSB-first)
// share the stimulus and are compared each cycle against a frame-level model
// that keeps the received bits in a queue, plus directed constant checks.
module tb_uart_sipo_deserializer;

`ifdef UART_SIPO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam bit PODD = 1'b0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0, data_in = 1'b0, read = 1'b0, data_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] out_l, out_m;
  logic       ov_l, ov_m, ferr_l, ferr_m, orun_l, orun_m, perr_l, perr_m;
  logic [4:0] cnt_l, cnt_m;

  int errors = 0;
  int checks = 0;

  uart_sipo_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .PARITY_ODD(PODD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_in(data_in), .read(read),
    .data_valid(data_valid), .out(out_l), .out_valid(ov_l), .out_ready(out_ready),
    .bit_cnt(cnt_l), .frame_err(ferr_l), .overrun(orun_l), .parity_err(perr_l));

  uart_sipo_deserializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .PARITY_ODD(PODD)) dut_m (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .data_in(data_in), .read(read),
    .data_valid(data_valid), .out(out_m), .out_valid(ov_m), .out_ready(out_ready),
    .bit_cnt(cnt_m), .frame_err(ferr_m), .overrun(orun_m), .parity_err(perr_m));

  always #5 clk = ~clk;

  // Reference model state: bits of the current frame in arrival order.
  bit         m_bits[$];
  logic [7:0] m_out_l = '0, m_out_m = '0;
  logic       m_ov = 0, m_ferr = 0, m_orun = 0, m_perr = 0;

  function automatic logic [7:0] mword(input bit msb_first);
    logic [7:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      if (msb_first) w[7-i] = m_bits[i];
      else           w[i]   = m_bits[i];
    end
    return w;
  endfunction

  function automatic logic mparity();
    int ones = 0;
    for (int i = 0; i < FL; i++) ones += int'(m_bits[i]);
`ifdef UART_SIPO_PARITY_EN
    return (ones % 2) != int'(PODD);
`else
    return (ones < 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic fs, input logic din, input logic rd,
                            input logic dv, input logic rdy, input logic rstn);
    bit full;
    full = (m_bits.size() == FL);
    if (!rstn) begin
      m_bits.delete();
      m_out_l = '0; m_out_m = '0; m_ov = 0; m_ferr = 0; m_orun = 0; m_perr = 0;
      return;
    end
    m_ferr = dv && !full;
    if (dv && full && (!m_ov || rdy)) begin
      m_out_l = mword(1'b0);
      m_out_m = mword(1'b1);
      m_ov    = 1;
      m_perr  = mparity();
    end else begin
      if (dv && full) m_orun = 1;
      if (m_ov && rdy) m_ov = 0;
    end
    if (fs || dv) m_bits.delete();
    else if (rd && !full) m_bits.push_back(din);
  endtask

  // One clock: drive, update the model at the edge, compare 1 time unit later.
  task automatic tick(input logic fs, input logic din, input logic rd,
                      input logic dv, input logic rdy, input logic rstn);
    frame_start = fs; data_in = din; read = rd; data_valid = dv; out_ready = rdy; rst_n = rstn;
    @(posedge clk);
    model_step(fs, din, rd, dv, rdy, rstn);
    #1;
    check("out_lsb",   32'(out_l),  32'(m_out_l));
    check("out_msb",   32'(out_m),  32'(m_out_m));
    check("out_valid", 32'(ov_l),   32'(m_ov));
    check("ov_msb",    32'(ov_m),   32'(m_ov));
    check("bit_cnt",   32'(cnt_l),  32'(m_bits.size()));
    check("cnt_msb",   32'(cnt_m),  32'(m_bits.size()));
    check("frame_err", 32'(ferr_l), 32'(m_ferr));
    check("overrun",   32'(orun_l), 32'(m_orun));
    check("parity",    32'(perr_l), 32'(m_perr));
    check("perr_msb",  32'(perr_m), 32'(m_perr));
  endtask

  // Frame start followed by the 8 data bits (w[0] first) and, if enabled, the parity bit.
  task automatic send_frame(input logic [7:0] w, input logic pbit, input logic rdy);
    tick(1, 0, 0, 0, rdy, 1);
    for (int i = 0; i < 8; i++) tick(0, w[i], 1, 0, rdy, 1);
`ifdef UART_SIPO_PARITY_EN
    tick(0, pbit, 1, 0, rdy, 1);
`else
    if (pbit) tick(0, 0, 0, 0, rdy, 1);
`endif
  endtask

  initial begin
    // Reset state
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_out", 32'(out_l), 0);
    check("rst_valid", 32'(ov_l), 0);
    check("rst_cnt", 32'(cnt_l), 0);
    check("rst_overrun", 32'(orun_l), 0);

    // Bits 1,0,1,1,0,0,1,0 -> 4D LSB-first, B2 MSB-first
    send_frame(8'h4D, 1'b0, 0);
    tick(0, 0, 0, 1, 0, 1);
    check("t1_out", 32'(out_l), 32'h4D);
    check("t2_out_msb", 32'(out_m), 32'hB2);
    check("t1_valid", 32'(ov_l), 1);
    check("t1_cnt", 32'(cnt_l), 0);
    check("t1_ferr", 32'(ferr_l), 0);
    check("t1_perr", 32'(perr_l), 0);

    // Short frame: 5 reads then commit
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    check("t3_ferr", 32'(ferr_l), 1);
    check("t3_valid", 32'(ov_l), 1);
    check("t3_out", 32'(out_l), 32'h4D);
    check("t3_cnt", 32'(cnt_l), 0);
    tick(0, 0, 0, 0, 0, 1);
    check("t3_ferr_pulse", 32'(ferr_l), 0);

    // Excess reads saturate the bit count
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) tick(0, 1'($urandom_range(0, 1)), 1, 0, 0, 1);
    check("sat_cnt", 32'(cnt_l), FL);
    tick(0, 0, 0, 0, 1, 1);
    check("consume_valid", 32'(ov_l), 0);
    tick(0, 0, 0, 1, 0, 1);

    // Overrun: hold out_ready low across two commits
    tick(0, 0, 0, 0, 1, 1);
    send_frame(8'hA5, 1'b0, 0);
    tick(0, 0, 0, 1, 0, 1);
    send_frame(8'h3C, 1'b0, 0);
    tick(0, 0, 0, 1, 0, 1);
    check("t4_out", 32'(out_l), 32'hA5);
    check("t4_overrun", 32'(orun_l), 1);
    tick(0, 0, 0, 0, 1, 1);
    check("t4_valid_drop", 32'(ov_l), 0);
    tick(0, 0, 0, 0, 0, 1);
    check("t4_overrun_sticky", 32'(orun_l), 1);

    // Back-to-back accept and commit
    tick(0, 0, 0, 0, 0, 0);
    send_frame(8'hA5, 1'b0, 0);
    tick(0, 0, 0, 1, 0, 1);
    send_frame(8'h3C, 1'b0, 0);
    tick(0, 0, 0, 1, 1, 1);
    check("t5_out", 32'(out_l), 32'h3C);
    check("t5_valid", 32'(ov_l), 1);
    check("t5_overrun", 32'(orun_l), 0);

`ifdef UART_SIPO_PARITY_EN
    // Wrong parity bit on 4D under even parity
    tick(0, 0, 0, 0, 1, 1);
    send_frame(8'h4D, 1'b1, 0);
    tick(0, 0, 0, 1, 0, 1);
    check("t6_perr", 32'(perr_l), 1);
`endif

    // Random complete frames with random handshake
    for (int n = 0; n < 40; n++) begin
      logic [7:0] w;
      w = 8'($urandom);
      tick(1, 0, 0, 0, 1'($urandom_range(0, 1)), 1);
      for (int i = 0; i < FL; i++) begin
        if ($urandom_range(0, 3) == 0) tick(0, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)), 1);
        tick(0, (i < 8) ? w[i] : 1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)), 1);
      end
      tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 1);
      if ($urandom_range(0, 1) == 0) tick(0, 0, 0, 0, 1'($urandom_range(0, 1)), 1);
    end

    // Fully random control
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 96) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
